// File: rtl/bus_ctl.sv
// Z8S180 memory-bus sequencer: boot ROM overlay / SRAM decode, strobe generation, optional waits.
// Optional wait-state generation is compiled in with the macro BUS_CTL_WAIT_GEN_EN.
module bus_ctl #(
  parameter int          ROM_AW      = 9,
  parameter logic [7:0]  BOOT_PORT   = 8'h00,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        hwclk,
  input  logic        reset,
  input  logic [19:0] a,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  output logic        d_oe,
  output logic        ce_n,
  output logic        oe_n,
  output logic        we_n,
  output logic        wait_n,
  output logic        boot_en
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef BUS_CTL_WAIT_GEN_EN
    S_WAIT = 2'd2,
`endif
    S_ACC  = 2'd1
  } state_t;

  // CPU strobes are asynchronous to hwclk: two-flop synchronisers, idle-high.
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic       w_smreq, w_siorq, w_srd, w_swr;

  always_ff @(posedge hwclk) begin
    if (reset) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
    end else begin
      r_sync1 <= {mreq_n, iorq_n, rd_n, wr_n};
      r_sync2 <= r_sync1;
    end
  end

  assign w_smreq = r_sync2[3];
  assign w_siorq = r_sync2[2];
  assign w_srd   = r_sync2[1];
  assign w_swr   = r_sync2[0];

  state_t r_state, w_state_next;
  logic   r_rom, w_rom_next;
  logic   r_rd, w_rd_next;
  logic   r_boot_en;
  logic   w_start, w_rom_hit, w_boot_clr;

  assign w_start    = ~w_smreq & (~w_srd | ~w_swr);
  assign w_rom_hit  = r_boot_en & (a[19:ROM_AW] == '0);
  // A simultaneous memory request takes priority over the boot-disable I/O write.
  assign w_boot_clr = ~w_siorq & ~w_swr & w_smreq & (a[7:0] == BOOT_PORT);

`ifdef BUS_CTL_WAIT_GEN_EN
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [CW-1:0] r_ctr, w_ctr_next;

  always_ff @(posedge hwclk) begin
    if (reset) r_ctr <= '0;
    else       r_ctr <= w_ctr_next;
  end
`endif

  always_ff @(posedge hwclk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_rom     <= 1'b0;
      r_rd      <= 1'b0;
      r_boot_en <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_rom   <= w_rom_next;
      r_rd    <= w_rd_next;
      if (w_boot_clr) r_boot_en <= 1'b0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_rom_next   = r_rom;
    w_rd_next    = r_rd;
`ifdef BUS_CTL_WAIT_GEN_EN
    w_ctr_next   = r_ctr;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_rom_next   = w_rom_hit;
          w_rd_next    = ~w_srd;
          w_state_next = S_ACC;
`ifdef BUS_CTL_WAIT_GEN_EN
          if (WAIT_CYCLES > 0) begin
            w_state_next = S_WAIT;
            w_ctr_next   = CW'(WAIT_CYCLES - 1);
          end
`endif
        end
      end
`ifdef BUS_CTL_WAIT_GEN_EN
      S_WAIT: begin
        if (r_ctr == '0) w_state_next = S_ACC;
        else             w_ctr_next   = r_ctr - 1'b1;
      end
`endif
      S_ACC: begin
        if (w_smreq) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  logic w_active;
  logic w_d_oe_next, w_ce_n_next, w_oe_n_next, w_we_n_next, w_wait_n_next;

  always_comb begin
    w_active      = (w_state_next != S_IDLE);
    w_d_oe_next   = w_active & w_rom_next & w_rd_next;
    w_ce_n_next   = ~(w_active & ~w_rom_next);
    w_oe_n_next   = ~(w_active & ~w_rom_next & w_rd_next);
    w_we_n_next   = ~(w_active & ~w_rom_next & ~w_rd_next);
    w_wait_n_next = 1'b1;
`ifdef BUS_CTL_WAIT_GEN_EN
    w_wait_n_next = (w_state_next != S_WAIT);
`endif
  end

  logic r_d_oe, r_ce_n, r_oe_n, r_we_n, r_wait_n;

  always_ff @(posedge hwclk) begin
    if (reset) begin
      r_d_oe   <= 1'b0;
      r_ce_n   <= 1'b1;
      r_oe_n   <= 1'b1;
      r_we_n   <= 1'b1;
      r_wait_n <= 1'b1;
    end else begin
      r_d_oe   <= w_d_oe_next;
      r_ce_n   <= w_ce_n_next;
      r_oe_n   <= w_oe_n_next;
      r_we_n   <= w_we_n_next;
      r_wait_n <= w_wait_n_next;
    end
  end

  assign d_oe    = r_d_oe;
  assign ce_n    = r_ce_n;
  assign oe_n    = r_oe_n;
  assign we_n    = r_we_n;
  assign boot_en = r_boot_en;

`ifdef BUS_CTL_WAIT_GEN_EN
  assign wait_n = r_wait_n;
  logic w_unused_bits;
  assign w_unused_bits = ^a;
`else
  assign wait_n = 1'b1;
  logic w_unused_bits;
  assign w_unused_bits = ^{a, r_wait_n, (WAIT_CYCLES != 0)};
`endif

endmodule

// File: tb/tb_bus_ctl.sv
// Directed bench for bus_ctl: reset, ROM overlay, SRAM strobes, wait states, boot disable, refresh.
module tb_bus_ctl;

`ifdef BUS_CTL_WAIT_GEN_EN
  localparam int EXP_WAIT = 2;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic        hwclk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] a = '0;
  logic        mreq_n = 1'b1;
  logic        iorq_n = 1'b1;
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;
  logic        d_oe, ce_n, oe_n, we_n, wait_n, boot_en;

  int checks = 0;
  int errors = 0;

  bus_ctl #(.ROM_AW(9), .BOOT_PORT(8'h00), .WAIT_CYCLES(2)) dut (
    .hwclk(hwclk), .reset(reset), .a(a),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .d_oe(d_oe), .ce_n(ce_n), .oe_n(oe_n), .we_n(we_n),
    .wait_n(wait_n), .boot_en(boot_en)
  );

  always #5 hwclk = ~hwclk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge hwclk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a memory cycle and wait until the FSM has seen it (2 sync edges + 1 FSM edge).
  task automatic mem_start(input logic [19:0] addr, input logic is_rd);
    a = addr;
    mreq_n = 1'b0;
    if (is_rd) rd_n = 1'b0;
    else       wr_n = 1'b0;
    tick(3);
  endtask

  task automatic release_all();
    mreq_n = 1'b1;
    iorq_n = 1'b1;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
    tick(3);
  endtask

  task automatic io_write(input logic [7:0] port);
    a = {12'h000, port};
    iorq_n = 1'b0;
    wr_n   = 1'b0;
    tick(3);
    release_all();
  endtask

  initial begin
    int nlow;
    // 1. reset
    tick(3);
    chk("rst_d_oe", d_oe, 0);
    chk("rst_ce_n", ce_n, 1);
    chk("rst_oe_n", oe_n, 1);
    chk("rst_we_n", we_n, 1);
    chk("rst_wait_n", wait_n, 1);
    chk("rst_boot_en", boot_en, 1);
    reset = 1'b0;
    tick(1);
    chk("post_rst_ce_n", ce_n, 1);
    $display("T1 reset done");

    // 2. ROM read with wait states
    mem_start(20'h00010, 1'b1);
    chk("rom_rd_d_oe_enter", d_oe, 1);
    chk("rom_rd_ce_n_enter", ce_n, 1);
    nlow = 0;
    while (wait_n == 1'b0 && nlow < 10) begin
      nlow++;
      tick(1);
    end
    chk("rom_rd_wait_len", nlow, EXP_WAIT);
    chk("rom_rd_d_oe_acc", d_oe, 1);
    chk("rom_rd_ce_n_acc", ce_n, 1);
    chk("rom_rd_oe_n_acc", oe_n, 1);
    mreq_n = 1'b1;
    rd_n = 1'b1;
    tick(2);
    chk("rom_rd_d_oe_hold", d_oe, 1);
    tick(1);
    chk("rom_rd_d_oe_off", d_oe, 0);
    $display("T2 rom read: wait_n low %0d cycles", nlow);

    // 3. boot disable then SRAM read at the former ROM address
    io_write(8'h00);
    chk("boot_clr", boot_en, 0);
    mem_start(20'h00010, 1'b1);
    chk("sram_rd_ce_n", ce_n, 0);
    chk("sram_rd_oe_n", oe_n, 0);
    chk("sram_rd_we_n", we_n, 1);
    chk("sram_rd_d_oe", d_oe, 0);
    tick(EXP_WAIT);
    chk("sram_rd_ce_n_acc", ce_n, 0);
    release_all();
    chk("sram_rd_ce_n_end", ce_n, 1);
    chk("sram_rd_oe_n_end", oe_n, 1);
    $display("T3 boot disable + sram read");

    // 4. ROM write ignored, SRAM write strobes
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    mem_start(20'h00005, 1'b0);
    tick(EXP_WAIT);
    chk("rom_wr_ce_n", ce_n, 1);
    chk("rom_wr_we_n", we_n, 1);
    chk("rom_wr_oe_n", oe_n, 1);
    chk("rom_wr_d_oe", d_oe, 0);
    release_all();
    mem_start(20'h10000, 1'b0);
    tick(EXP_WAIT);
    chk("sram_wr_ce_n", ce_n, 0);
    chk("sram_wr_we_n", we_n, 0);
    chk("sram_wr_oe_n", oe_n, 1);
    chk("sram_wr_d_oe", d_oe, 0);
    release_all();
    chk("sram_wr_we_n_end", we_n, 1);
    $display("T4 rom write ignored, sram write");

    // ROM overlay boundary
    mem_start(20'h001FF, 1'b1);
    tick(EXP_WAIT);
    chk("top_rom_d_oe", d_oe, 1);
    chk("top_rom_ce_n", ce_n, 1);
    release_all();
    mem_start(20'h00200, 1'b1);
    tick(EXP_WAIT);
    chk("above_rom_d_oe", d_oe, 0);
    chk("above_rom_ce_n", ce_n, 0);
    chk("above_rom_oe_n", oe_n, 0);
    release_all();
    $display("T4b overlay boundary");

    // Non-matching port, and memory path winning over simultaneous I/O write
    io_write(8'h01);
    chk("other_port_boot", boot_en, 1);
    a = 20'h00000;
    mreq_n = 1'b0;
    iorq_n = 1'b0;
    wr_n = 1'b0;
    tick(3 + EXP_WAIT);
    chk("mreq_iorq_boot", boot_en, 1);
    chk("mreq_iorq_ce_n", ce_n, 1);
    release_all();
    chk("mreq_iorq_boot_end", boot_en, 1);
    $display("T4c port decode");

    // 5. refresh
    a = 20'h10000;
    mreq_n = 1'b0;
    tick(5);
    chk("refresh_ce_n", ce_n, 1);
    chk("refresh_oe_n", oe_n, 1);
    chk("refresh_we_n", we_n, 1);
    chk("refresh_d_oe", d_oe, 0);
    chk("refresh_wait_n", wait_n, 1);
    release_all();
    $display("T5 refresh");

    // 6. reset during WAIT of an SRAM read
    io_write(8'h00);
    chk("t6_boot_clr", boot_en, 0);
    mem_start(20'h00010, 1'b1);
    chk("t6_wait_n_pre", wait_n, (EXP_WAIT == 0) ? 1 : 0);
    chk("t6_ce_n_pre", ce_n, 0);
    reset = 1'b1;
    tick(1);
    chk("t6_wait_n", wait_n, 1);
    chk("t6_ce_n", ce_n, 1);
    chk("t6_oe_n", oe_n, 1);
    chk("t6_d_oe", d_oe, 0);
    chk("t6_boot_en", boot_en, 1);
    mreq_n = 1'b1;
    rd_n = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(3);
    chk("t6_idle_ce_n", ce_n, 1);
    $display("T6 reset during wait");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
